// File: rtl/edge_count_window.sv
// Gated edge counter: counts synchronised rising edges of signal_in over
// back-to-back windows of `period` clocks and publishes each window's total.
module edge_count_window #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 8,
    parameter int PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                signal_in,
    input  logic [PERIOD_W-1:0] period,
    output logic [COUNT_W-1:0]  count_out,
    output logic                valid,
    output logic                overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_det;

    state_t                 state_q;
    logic [PERIOD_W-1:0]    len_q;
    logic [PERIOD_W-1:0]    timer_q;
    logic [COUNT_W-1:0]     cnt_q;
    logic                   sat_q;
    logic [COUNT_W-1:0]     count_q;
    logic                   valid_q;
    logic                   ovf_q;

    logic [PERIOD_W-1:0]    last_tick;
    logic                   win_end;
    logic                   cnt_full;
    logic [COUNT_W-1:0]     cnt_d;
    logic                   sat_d;

    // Synchroniser and history run even when disabled so re-enable sees no stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det  = sync_q[SYNC_STAGES-1] & ~hist_q;

    // A latched length of 0 behaves as 1, so the last tick is timer 0.
    assign last_tick = (len_q == '0) ? '0 : len_q - PERIOD_W'(1);
    assign win_end   = (timer_q == last_tick);
    assign cnt_full  = &cnt_q;
    assign cnt_d     = (edge_det && !cnt_full) ? cnt_q + COUNT_W'(1) : cnt_q;
    assign sat_d     = sat_q | (edge_det & cnt_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    cnt_q   <= '0;
                    sat_q   <= 1'b0;
                    if (ena) begin
                        state_q <= GATE;
                        len_q   <= period;
                    end
                end
                GATE: begin
                    if (!ena) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                    end else if (win_end) begin
                        // Closing-cycle edge belongs to this window; next window starts immediately.
                        count_q <= cnt_d;
                        ovf_q   <= sat_d;
                        valid_q <= 1'b1;
                        timer_q <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        len_q   <= period;
                    end else begin
                        timer_q <= timer_q + PERIOD_W'(1);
                        cnt_q   <= cnt_d;
                        sat_q   <= sat_d;
                    end
                end
            endcase
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_edge_count_window.sv
// Bench for edge_count_window: directed scenarios plus random traffic, every
// cycle compared against a window-level model using unbounded edge totals.
module tb_edge_count_window;

    localparam int S    = 2;
    localparam int CW   = 8;
    localparam int PW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          signal_in = 1'b0;
    logic [PW-1:0] period = '0;
    logic [CW-1:0] count_out;
    logic          valid;
    logic          overflow;

    edge_count_window #(.SYNC_STAGES(S), .COUNT_W(CW), .PERIOD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .signal_in(signal_in),
        .period(period), .count_out(count_out), .valid(valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: past samples of signal_in, window position and raw edge total.
    int sq[S+1];
    bit m_gate;
    int m_len, m_t, m_edges;
    int exp_cnt;
    bit exp_ovf, exp_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        foreach (sq[i]) sq[i] = 0;
        m_gate = 0; m_len = 0; m_t = 0; m_edges = 0;
        exp_cnt = 0; exp_ovf = 0; exp_vld = 0;
    endtask

    function automatic int eff_len(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic mdl_clock();
        int e;
        if (!rst_n) begin
            mdl_reset();
        end else begin
            e = (sq[S-1] == 1 && sq[S] == 0) ? 1 : 0;
            for (int i = S; i > 0; i--) sq[i] = sq[i-1];
            sq[0] = int'(signal_in);
            exp_vld = 0;
            if (!m_gate) begin
                if (ena) begin
                    m_gate = 1; m_len = eff_len(int'(period)); m_t = 0; m_edges = 0;
                end
            end else if (!ena) begin
                m_gate = 0;
            end else begin
                m_edges += e;
                if (m_t == m_len - 1) begin
                    exp_cnt = (m_edges > CMAX) ? CMAX : m_edges;
                    exp_ovf = (m_edges > CMAX);
                    exp_vld = 1;
                    m_t = 0; m_edges = 0; m_len = eff_len(int'(period));
                end else begin
                    m_t++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        mdl_clock();
        #1;
        chk("valid", valid, exp_vld);
        chk("count_out", count_out, exp_cnt);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int k;
        int vpos[$];
        mdl_reset();
        #1;
        chk("rst_count", count_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", overflow, 0);
        run(3);
        rst_n = 1'b1;

        // Square wave of period 10 over 100-cycle windows
        period = 100; ena = 1'b1;
        for (int c = 0; c < 250; c++) begin
            signal_in = ((c / 5) % 2) != 0;
            step();
        end
        chk("win100_count", count_out, 10);
        chk("win100_ovf", overflow, 0);

        // Async reset mid-window with signal_in held high across release
        signal_in = 1'b1;
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("async_rst_count", count_out, 0);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_ovf", overflow, 0);
        step();
        rst_n = 1'b1; period = 10;
        run(12);
        chk("high_at_release_count", count_out, 1);
        period = 0;
        run(9);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p0_valid_every_cycle", valid, 1);
        end

        // Single edge detected on the closing cycle of a 50-cycle window
        ena = 1'b0; period = 50; signal_in = 1'b0;
        run(4);
        ena = 1'b1;
        for (int j = 1; j <= 101; j++) begin
            if (j == 49 - S + 2) signal_in = 1'b1;
            step();
            if (j == 51) begin
                chk("last_tick_valid", valid, 1);
                chk("last_tick_count", count_out, 1);
            end
            if (j == 101) chk("next_window_zero", count_out, 0);
        end

        // Abort partway through a window, then re-enable latency
        ena = 1'b0; signal_in = 1'b0;
        run(3);
        period = 100; ena = 1'b1;
        for (int c = 0; c < 170; c++) begin
            signal_in = ((c / 5) % 2) != 0;
            step();
        end
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("abort_hold_count", count_out, 10);
        end
        ena = 1'b1;
        k = 0;
        while (k < 200) begin
            k++;
            step();
            if (valid) break;
        end
        chk("reenable_latency", k, 101);

        // Period change at timer 30 takes effect at the next boundary
        ena = 1'b0; signal_in = 1'b0;
        run(3);
        period = 100; ena = 1'b1;
        run(31);
        period = 40;
        for (int j = 32; j <= 200; j++) begin
            step();
            if (valid) vpos.push_back(j);
        end
        chk("period_chg_nvalid", vpos.size(), 3);
        if (vpos.size() >= 3) begin
            chk("period_chg_first", vpos[0], 101);
            chk("period_chg_second", vpos[1], 141);
            chk("period_chg_third", vpos[2], 181);
        end

        // Saturation, then a clean 20-edge window
        ena = 1'b0; signal_in = 1'b0;
        run(3);
        period = 1000; ena = 1'b1;
        for (int j = 1; j <= 1001; j++) begin
            signal_in = (j % 2) != 0;
            step();
        end
        chk("sat_count", count_out, CMAX);
        chk("sat_ovf", overflow, 1);
        ena = 1'b0; signal_in = 1'b0;
        run(5);
        ena = 1'b1;
        for (int j = 1; j <= 1001; j++) begin
            signal_in = (j <= 400) ? ((((j - 1) / 10) % 2) != 0) : 1'b0;
            step();
        end
        chk("post_sat_count", count_out, 20);
        chk("post_sat_ovf", overflow, 0);

        // Random traffic with short windows, ena dropouts and reset pulses
        period = 3;
        for (int i = 0; i < 1500; i++) begin
            ena = ($urandom_range(15) != 0);
            signal_in = $urandom_range(1) != 0;
            if ($urandom_range(19) == 0) period = PW'($urandom_range(5));
            if ($urandom_range(249) == 0) begin
                #2 rst_n = 1'b0;
                mdl_reset();
                #1;
                chk("rand_rst_count", count_out, 0);
                chk("rand_rst_valid", valid, 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_count_window.md
EDGE_COUNT_WINDOW -- requirements
Module: edge_count_window

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on signal_in (legal 2..4).
REQ-002 Parameter COUNT_W, default 8, width of the edge counter and count_out.
REQ-003 Parameter PERIOD_W, default 16, width of the period input.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronous to clk.
REQ-006 ena  input  1  block enable; low holds the block idle.
REQ-007 signal_in  input  1  external signal to measure; asynchronous to clk.
REQ-008 period  input  PERIOD_W  gate window length in clk cycles.
REQ-009 count_out  output  COUNT_W  rising edges counted in the last completed window.
REQ-010 valid  output  1  one-cycle pulse marking a count_out update.
REQ-011 overflow  output  1  set when the last completed window saturated; updated with valid.

Function
REQ-012 signal_in SHALL pass through SYNC_STAGES flops, then one history flop; a rising edge is synchronised value 1 with history value 0.
REQ-013 An input rising edge SHALL be detected SYNC_STAGES+1 cycles after it is sampled (3 cycles at default).
REQ-014 States SHALL be IDLE and GATE only.
REQ-015 IDLE: timer and edge counter held at 0; ena=1 SHALL move to GATE next cycle and latch period into the window length register.
REQ-016 A latched period of 0 SHALL be treated as 1.
REQ-017 GATE: the timer SHALL count 0..L-1 (L = latched length); each detected edge SHALL increment the edge counter.
REQ-018 The edge counter SHALL saturate at 2^COUNT_W-1 and never wrap; a saturation flag SHALL record any edge lost to saturation.
REQ-019 On the cycle with timer = L-1, the next cycle SHALL load count_out with the edge counter plus that cycle's edge (saturating), load overflow with the saturation flag, and pulse valid.
REQ-020 An edge detected on the timer = L-1 cycle SHALL belong to the closing window, not the next one.
REQ-021 On the same transition the timer, edge counter and saturation flag SHALL clear, and period SHALL be re-latched; windows SHALL be back-to-back, with no dead cycles.
REQ-022 period changes mid-window SHALL have no effect until the next window boundary.
REQ-023 ena=0 in GATE SHALL abort the window next cycle and return to IDLE with no valid pulse; count_out and overflow SHALL hold their last values.
REQ-024 Synchroniser and history flops SHALL run regardless of ena, so no false edge appears on re-enable.
REQ-025 valid SHALL never be high for two consecutive cycles unless L = 1.

Reset
REQ-026 Under rst_n=0: count_out=0, valid=0, overflow=0, state=IDLE, timer=0, edge counter=0, saturation flag=0, all synchroniser and history flops=0, latched length=0.
REQ-027 Reset asserted mid-window SHALL discard the partial count with no valid pulse.
REQ-028 If signal_in is high when reset deasserts, that SHALL count as one rising edge after synchronisation.

Verification
REQ-029 Reset, ena=1, period=100, signal_in toggling every 5 clk (period 10 clk) -> valid every 100 clk, count_out=10, overflow=0.
REQ-030 period=50, single edge timed to be detected on timer=49 -> that window reports 1, the next window reports 0.
REQ-031 period=1000, signal_in toggling every clk (period 2 clk) -> count_out=255, overflow=1; then period=1000 with 20 edges -> count_out=20, overflow=0.
REQ-032 Window running with 7 edges counted, ena dropped -> no valid, count_out holds its prior value; ena raised again -> new full window starts and its first valid is exactly L+1 cycles later.
REQ-033 period changed from 100 to 40 at timer=30 -> current window still 100 cycles; following windows 40 cycles.
REQ-034 rst_n pulsed low mid-window -> all outputs 0 immediately and no valid until one full window after ena is seen in IDLE; period=0 -> valid every cycle.
